// File: rtl/counter_scheduler.sv
// Round-robin scheduler that lends one shared 10-cycle counter to NUM_REQ requesters,
// running it RUNS_PER_GRANT periods per grant with a watchdog abort.
module counter_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int RUNS_PER_GRANT = 1,
    parameter int WDOG_CYCLES    = 12
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [NUM_REQ-1:0] o_done,
    output logic [NUM_REQ-1:0] o_err,
    output logic               o_busy,
    output logic               o_cnt_ena,
    input  logic               i_cnt_done
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW:0]      NUM_REQ_W = (IDXW + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} stateT;

    stateT               r_state;
    stateT               w_nextState;
    logic [IDXW-1:0]     r_winner;
    logic [IDXW-1:0]     r_rrPtr;
    logic [3:0]          r_runCnt;
    logic [7:0]          r_wdog;

    logic [2*NUM_REQ-1:0] w_reqTwice;
    logic [NUM_REQ-1:0]   w_reqRot;
    logic [IDXW-1:0]      w_off;
    logic [IDXW:0]        w_sum;
    logic [IDXW-1:0]      w_pick;
    logic [IDXW-1:0]      w_nextPtr;
    logic                 w_found;
    logic                 w_lastRun;
    logic                 w_wdogExpired;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [NUM_REQ-1:0]   w_done;
    logic [NUM_REQ-1:0]   w_err;
    logic                 w_busy;
    logic                 w_ena;

    assign w_found       = |i_req;
    assign w_lastRun     = (r_runCnt == 4'(RUNS_PER_GRANT - 1));
    assign w_wdogExpired = (r_wdog == 8'(WDOG_CYCLES - 1));
    assign w_nextPtr     = (r_winner == IDXW'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

    // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    assign w_reqTwice = {i_req, i_req} >> r_rrPtr;
    assign w_reqRot   = w_reqTwice[NUM_REQ-1:0];
    assign w_sum      = {1'b0, r_rrPtr} + {1'b0, w_off};
    assign w_pick     = (w_sum >= NUM_REQ_W) ? IDXW'(w_sum - NUM_REQ_W) : w_sum[IDXW-1:0];

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_reqRot[i]) begin
                w_off = IDXW'(i);
            end
        end
    end

    // State register; outputs are registered alongside it from the next-state decode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            o_gnt     <= '0;
            o_done    <= '0;
            o_err     <= '0;
            o_busy    <= 1'b0;
            o_cnt_ena <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            o_gnt     <= w_gnt;
            o_done    <= w_done;
            o_err     <= w_err;
            o_busy    <= w_busy;
            o_cnt_ena <= w_ena;
        end
    end

    // A done flag takes priority over a simultaneous watchdog expiry.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_found) w_nextState = RUN;
            RUN: begin
                if (i_cnt_done) begin
                    if (w_lastRun) w_nextState = DONE;
                end else if (w_wdogExpired) begin
                    w_nextState = ERR;
                end
            end
            DONE:    w_nextState = IDLE;
            ERR:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_gnt  = '0;
        w_done = '0;
        w_err  = '0;
        w_busy = (w_nextState != IDLE);
        w_ena  = (w_nextState == RUN);
        case (w_nextState)
            RUN:     w_gnt  = (r_state == IDLE) ? (ONE_HOT0 << w_pick) : (ONE_HOT0 << r_winner);
            DONE:    w_done = ONE_HOT0 << r_winner;
            ERR:     w_err  = ONE_HOT0 << r_winner;
            default: ;
        endcase
    end

    // Grant bookkeeping: winner latch, period count, watchdog and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_winner <= '0;
            r_rrPtr  <= '0;
            r_runCnt <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_winner <= w_pick;
                        r_runCnt <= '0;
                        r_wdog   <= '0;
                    end
                end
                RUN: begin
                    if (i_cnt_done && !w_lastRun) begin
                        r_runCnt <= r_runCnt + 4'd1;
                        r_wdog   <= '0;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                default: r_rrPtr <= w_nextPtr;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus random grants
// checked cycle by cycle against a timing/arbitration model derived from the grant rules.
module tb_counter_scheduler;

   localparam int WDOG = 12;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [3:0] req1 = 4'b0;
   logic [3:0] req2 = 4'b0;
   logic [3:0] gnt1, done1, err1, gnt2, done2, err2;
   logic       busy1, ena1, busy2, ena2;
   logic       cntDone1, cntDone2;
   logic       killDone = 1'b0;
   logic       forceDone = 1'b0;
   logic [3:0] cnt1, cnt2;
   int         testsRun = 0;
   int         failCount = 0;
   int         ptr1 = 0;
   int         ptr2 = 0;

   always #5 clk = ~clk;

   // Behavioural 10-cycle counters feeding each scheduler.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) cnt1 <= 4'd0;
      else if (ena1) cnt1 <= (cnt1 == 4'd9) ? 4'd0 : cnt1 + 4'd1;
      else cnt1 <= 4'd0;
   end

   always @(posedge clk or negedge rstN) begin
      if (!rstN) cnt2 <= 4'd0;
      else if (ena2) cnt2 <= (cnt2 == 4'd9) ? 4'd0 : cnt2 + 4'd1;
      else cnt2 <= 4'd0;
   end

   assign cntDone1 = forceDone | (ena1 & (cnt1 == 4'd9) & ~killDone);
   assign cntDone2 = ena2 & (cnt2 == 4'd9);

   counter_scheduler #(.NUM_REQ(4), .RUNS_PER_GRANT(1), .WDOG_CYCLES(WDOG)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_req(req1), .o_gnt(gnt1), .o_done(done1),
      .o_err(err1), .o_busy(busy1), .o_cnt_ena(ena1), .i_cnt_done(cntDone1)
   );

   counter_scheduler #(.NUM_REQ(4), .RUNS_PER_GRANT(2), .WDOG_CYCLES(WDOG)) dut2 (
      .i_clk(clk), .i_rst_n(rstN), .i_req(req2), .o_gnt(gnt2), .o_done(done2),
      .o_err(err2), .o_busy(busy2), .o_cnt_ena(ena2), .i_cnt_done(cntDone2)
   );

   // First requester at or after the pointer, cyclically.
   function automatic int pickWinner(input logic [3:0] req, input int ptr);
      pickWinner = -1;
      for (int i = 3; i >= 0; i--) begin
         if (req[(ptr + i) % 4]) pickWinner = (ptr + i) % 4;
      end
   endfunction

   task automatic applyStimulus(input bit second, input logic [3:0] reqVal);
      if (second) req2 = reqVal;
      else req1 = reqVal;
   endtask

   task automatic checkOutput(input string tag, input bit second, input logic [3:0] eGnt,
                              input logic [3:0] eDone, input logic [3:0] eErr,
                              input logic eBusy, input logic eEna);
      logic [3:0] g, d, e;
      logic       b, en;
      g  = second ? gnt2 : gnt1;
      d  = second ? done2 : done1;
      e  = second ? err2 : err1;
      b  = second ? busy2 : busy1;
      en = second ? ena2 : ena1;
      testsRun++;
      assert (g === eGnt) else begin
         failCount++;
         $error("FAIL %s gnt observed %b expected %b", tag, g, eGnt);
      end
      testsRun++;
      assert (d === eDone) else begin
         failCount++;
         $error("FAIL %s done observed %b expected %b", tag, d, eDone);
      end
      testsRun++;
      assert (e === eErr) else begin
         failCount++;
         $error("FAIL %s err observed %b expected %b", tag, e, eErr);
      end
      testsRun++;
      assert (b === eBusy) else begin
         failCount++;
         $error("FAIL %s busy observed %b expected %b", tag, b, eBusy);
      end
      testsRun++;
      assert (en === eEna) else begin
         failCount++;
         $error("FAIL %s ena observed %b expected %b", tag, en, eEna);
      end
   endtask

   task automatic applyReset();
      rstN = 1'b0;
      req1 = 4'b0;
      req2 = 4'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset dut", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      checkOutput("reset dut2", 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      ptr1 = 0;
      ptr2 = 0;
      rstN = 1'b1;
   endtask

   // One grant from the idle cycle in which the request is presented through the
   // idle cycle that follows DONE/ERR, checking every cycle.
   task automatic runGrant(input string tag, input bit second, input logic [3:0] reqVal,
                           input bit dropReq, input bit expectAbort);
      int         w;
      int         len;
      logic [3:0] oh;
      w   = pickWinner(reqVal, second ? ptr2 : ptr1);
      oh  = 4'b0001 << w;
      len = expectAbort ? WDOG : 10 * (second ? 2 : 1);
      applyStimulus(second, reqVal);
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         checkOutput(tag, second, oh, 4'b0, 4'b0, 1'b1, 1'b1);
         if (dropReq && c == 1) applyStimulus(second, 4'b0);
      end
      @(negedge clk);
      checkOutput(tag, second, 4'b0, expectAbort ? 4'b0 : oh, expectAbort ? oh : 4'b0, 1'b1, 1'b0);
      if (second) ptr2 = (w + 1) % 4;
      else ptr1 = (w + 1) % 4;
      @(negedge clk);
      checkOutput(tag, second, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0] rq;
      bit         drop, abort;
      int         gap;

      applyReset();

      runGrant("single req0", 1'b0, 4'b0001, 1'b1, 1'b0);

      forceDone = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("done in idle", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      end
      forceDone = 1'b0;

      applyReset();
      for (int k = 0; k < 4; k++) runGrant("alt 0101", 1'b0, 4'b0101, 1'b0, 1'b0);
      req1 = 4'b0;
      @(negedge clk);

      killDone = 1'b1;
      runGrant("watchdog", 1'b0, 4'b1000, 1'b1, 1'b1);
      killDone = 1'b0;

      applyReset();
      applyStimulus(1'b0, 4'b0001);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checkOutput("pre reset run", 1'b0, 4'b0001, 4'b0, 4'b0, 1'b1, 1'b1);
      end
      #2 rstN = 1'b0;
      #1 checkOutput("async reset", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      ptr1 = 0;
      ptr2 = 0;
      req1 = 4'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      for (int k = 0; k < 5; k++) runGrant("rr 1111", 1'b0, 4'b1111, 1'b0, 1'b0);
      req1 = 4'b0;
      @(negedge clk);

      runGrant("runs2", 1'b1, 4'b0010, 1'b1, 1'b0);

      for (int k = 0; k < 30; k++) begin
         rq    = 4'($urandom_range(1, 15));
         drop  = 1'($urandom_range(0, 1));
         abort = ($urandom_range(0, 4) == 0);
         killDone = abort;
         runGrant("random", 1'b0, rq, drop, abort);
         killDone = 1'b0;
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            req1 = 4'b0;
            repeat (gap) begin
               @(negedge clk);
               checkOutput("random gap", 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
